// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel counters plus registered hsync/vsync/de.
// Define TIMING_STROBES_EN to add the registered line_start/frame_start strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic       clk_pix,
  input  logic       rst,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       hsync,
  output logic       vsync,
  output logic       de
`ifdef TIMING_STROBES_EN
  ,
  output logic       line_start,
  output logic       frame_start
`endif
);

  // Totals must fit the 10-bit counters (defaults give 800 x 525).
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] sx_reg, sx_next;
  logic [9:0] sy_reg, sy_next;
  logic       hsync_reg, hsync_next;
  logic       vsync_reg, vsync_next;
  logic       de_reg, de_next;

  always_comb begin
    sx_next = sx_reg + 10'd1;
    sy_next = sy_reg;
    if (sx_reg == H_LAST) begin
      sx_next = '0;
      sy_next = (sy_reg == V_LAST) ? '0 : sy_reg + 10'd1;
    end
  end

  // Decode from the next counter values so every output lines up with sx/sy.
  always_comb begin
    hsync_next = ((sx_next >= HS_START) && (sx_next < HS_END)) ? H_POL : ~H_POL;
    vsync_next = ((sy_next >= VS_START) && (sy_next < VS_END)) ? V_POL : ~V_POL;
    de_next    = (sx_next < H_VIS) && (sy_next < V_VIS);
  end

  // Reset parks on the last pixel of a frame, so outputs are self-consistent.
  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      sx_reg    <= H_LAST;
      sy_reg    <= V_LAST;
      hsync_reg <= ~H_POL;
      vsync_reg <= ~V_POL;
      de_reg    <= 1'b0;
    end else begin
      sx_reg    <= sx_next;
      sy_reg    <= sy_next;
      hsync_reg <= hsync_next;
      vsync_reg <= vsync_next;
      de_reg    <= de_next;
    end
  end

  assign sx    = sx_reg;
  assign sy    = sy_reg;
  assign hsync = hsync_reg;
  assign vsync = vsync_reg;
  assign de    = de_reg;

`ifdef TIMING_STROBES_EN
  logic line_start_reg, line_start_next;
  logic frame_start_reg, frame_start_next;

  always_comb begin
    line_start_next  = (sx_next == 10'd0);
    frame_start_next = (sx_next == 10'd0) && (sy_next == 10'd0);
  end

  always_ff @(posedge clk_pix or negedge rst) begin
    if (!rst) begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance plus a tiny active-high-sync instance
// (15 x 8 raster) so full-frame behaviour is covered in few cycles.
module tb_vga_timing_gen;

  logic       clk_pix = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sx, sy, sx_s, sy_s;
  logic       hsync, vsync, de, hsync_s, vsync_s, de_s;
`ifdef TIMING_STROBES_EN
  logic       line_start, frame_start, line_start_s, frame_start_s;
`endif

  int n_cmp = 0;
  int n_err = 0;
  // Bench model positions: main (mx,my) and small (ssx,ssy).
  int mx, my, ssx, ssy;
  int cnt_de, cnt_hs, cnt_vs, cnt_ls, cnt_fs;

  always #5 clk_pix = ~clk_pix;

  vga_timing_gen dut (
    .clk_pix(clk_pix), .rst(rst), .sx(sx), .sy(sy),
    .hsync(hsync), .vsync(vsync), .de(de)
`ifdef TIMING_STROBES_EN
    , .line_start(line_start), .frame_start(frame_start)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut_s (
    .clk_pix(clk_pix), .rst(rst), .sx(sx_s), .sy(sy_s),
    .hsync(hsync_s), .vsync(vsync_s), .de(de_s)
`ifdef TIMING_STROBES_EN
    , .line_start(line_start_s), .frame_start(frame_start_s)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mx = 799; my = 524; ssx = 14; ssy = 7;
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
    if (rst) begin
      if (mx == 799) begin mx = 0; my = (my == 524) ? 0 : my + 1; end
      else mx = mx + 1;
      if (ssx == 14) begin ssx = 0; ssy = (ssy == 7) ? 0 : ssy + 1; end
      else ssx = ssx + 1;
    end else begin
      model_reset();
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".sx"}, 32'(sx), 32'(mx));
    check({ph, ".sy"}, 32'(sy), 32'(my));
    check({ph, ".de"}, 32'(de), 32'((mx < 640) && (my < 480)));
    check({ph, ".hsync"}, 32'(hsync), 32'(!((mx >= 656) && (mx < 752))));
    check({ph, ".vsync"}, 32'(vsync), 32'(!((my >= 490) && (my < 492))));
    check({ph, ".sx_s"}, 32'(sx_s), 32'(ssx));
    check({ph, ".sy_s"}, 32'(sy_s), 32'(ssy));
    check({ph, ".de_s"}, 32'(de_s), 32'((ssx < 8) && (ssy < 4)));
    check({ph, ".hsync_s"}, 32'(hsync_s), 32'((ssx >= 10) && (ssx < 13)));
    check({ph, ".vsync_s"}, 32'(vsync_s), 32'((ssy >= 5) && (ssy < 7)));
`ifdef TIMING_STROBES_EN
    check({ph, ".line_start"}, 32'(line_start), 32'(mx == 0));
    check({ph, ".frame_start"}, 32'(frame_start), 32'((mx == 0) && (my == 0)));
    check({ph, ".line_start_s"}, 32'(line_start_s), 32'(ssx == 0));
    check({ph, ".frame_start_s"}, 32'(frame_start_s), 32'((ssx == 0) && (ssy == 0)));
`endif
  endtask

  initial begin
    // Reset asserted (falling edge) and held for 5 clocks.
    #1 rst = 1'b0;
    model_reset();
    #1;
    check_all("rst_async");
    check("rst.sx", 32'(sx), 32'd799);
    check("rst.sy", 32'(sy), 32'd524);
    check("rst.hsync_s", 32'(hsync_s), 32'd0);
    check("rst.vsync_s", 32'(vsync_s), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("rst_hold");
    end

    // Release between edges; first edge lands on (0,0) with de=1.
    @(negedge clk_pix) rst = 1'b1;
    tick();
    check("rel.sx", 32'(sx), 32'd0);
    check("rel.sy", 32'(sy), 32'd0);
    check("rel.de", 32'(de), 32'd1);

    // Full first line, checked every pixel, plus directed boundary points.
    for (int c = 0; c < 800; c++) begin
      check_all("line");
      if (c == 639) check("line.de639", 32'(de), 32'd1);
      if (c == 640) check("line.de640", 32'(de), 32'd0);
      if (c == 655) check("line.hs655", 32'(hsync), 32'd1);
      if (c == 656) check("line.hs656", 32'(hsync), 32'd0);
      if (c == 751) check("line.hs751", 32'(hsync), 32'd0);
      if (c == 752) check("line.hs752", 32'(hsync), 32'd1);
      tick();
    end
    check("wrap.sx", 32'(sx), 32'd0);
    check("wrap.sy", 32'(sy), 32'd1);

    // Two complete frames of the small raster: 120 cycles each.
    cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_ls = 0; cnt_fs = 0;
    for (int c = 0; c < 240; c++) begin
      tick();
      check_all("frame_s");
      if (de_s) cnt_de++;
      if (hsync_s) cnt_hs++;
      if (vsync_s) cnt_vs++;
`ifdef TIMING_STROBES_EN
      if (line_start_s) cnt_ls++;
      if (frame_start_s) cnt_fs++;
`endif
    end
    check("frame_s.de_cnt", 32'(cnt_de), 32'd64);
    check("frame_s.hs_cnt", 32'(cnt_hs), 32'd48);
    check("frame_s.vs_cnt", 32'(cnt_vs), 32'd60);
`ifdef TIMING_STROBES_EN
    check("frame_s.ls_cnt", 32'(cnt_ls), 32'd16);
    check("frame_s.fs_cnt", 32'(cnt_fs), 32'd2);
`endif

    // Move to sx=300 and reset asynchronously mid-cycle.
    for (int c = 0; c < 800 && mx != 300; c++) begin
      tick();
      check_all("seek");
    end
    check("mid.pre_sx", 32'(sx), 32'd300);
    #3 rst = 1'b0;
    model_reset();
    #1;
    check_all("mid_rst");
    check("mid.sx", 32'(sx), 32'd799);
    check("mid.de", 32'(de), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_all("mid_hold");
    end
    @(negedge clk_pix) rst = 1'b1;
    tick();
    check_all("mid_rel");
    check("mid_rel.sx", 32'(sx), 32'd0);
    check("mid_rel.sy", 32'(sy), 32'd0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_all("post");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
